ddr_write_scheduler: RTL
========================

Name: ddr_write_scheduler

Overview:
Round-robin scheduler that shares one DDR burst write master between NUM_REQ requesters. It accepts burst descriptors (address and word count) and programs the master's control port. It streams each requester's words into the master's user buffer under buffer_full back-pressure, then waits for master_crtl_done and signals completion. It sits between the application write sources and the write master.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, byte address width
DATA_W, 32, word width; BPW = DATA_W/8 bytes per word
LEN_W, 8, word-count width per descriptor
TIMEOUT_CYCLES, 1024, done watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  descriptor pending, held until req_ack
req_addr  in  NUM_REQ*ADDR_W  byte base address, slot i at [i*ADDR_W +: ADDR_W]
req_words  in  NUM_REQ*LEN_W  burst length in words
req_ack  out  NUM_REQ  1-cycle pulse: descriptor accepted
req_rvalid  in  NUM_REQ  requester show-ahead data word available
req_rdata  in  NUM_REQ*DATA_W  show-ahead data words
req_rd  out  NUM_REQ  pop strobe, consumes req_rdata
req_done  out  NUM_REQ  1-cycle pulse: burst complete
req_err  out  NUM_REQ  1-cycle pulse with req_done on timeout (optional feature only)
busy  out  1  state != IDLE
master_crtl_fixed_location  out  1  tied 0
master_crtl_write_base  out  ADDR_W  latched base, low log2(BPW) bits forced 0
master_crtl_lenght  out  ADDR_W  latched words*BPW bytes
master_crtl_go  out  1  1-cycle start pulse
master_crtl_done  in  1  master idle/complete (level)
master_user_write_buffer  out  1  buffer write strobe
master_user_buffer_input_data  out  DATA_W  buffer write data
master_user_buffer_full  in  1  buffer cannot accept a word

Behaviour:
- Reset: state=IDLE, rr pointer=NUM_REQ-1 (so index 0 wins first). All outputs 0 (base, length, go, write_buffer, ack, rd, done, err, busy). Reset mid-burst abandons the burst; no req_done is issued. The master shares the same reset.
- States: IDLE, GO, STREAM, WAIT_DONE, RELEASE.
- IDLE: if any req_valid, grant g = first valid index after the rr pointer, wrapping. Latch base, length, remaining=words, and g. Pulse req_ack[g] in the same cycle.
  - If words==0, go to RELEASE; no go pulse and no master access.
  - Otherwise go to GO.
- GO: master_crtl_go=1 for exactly this cycle, then STREAM. Base and length stay stable from GO through RELEASE.
- STREAM: write = !master_user_buffer_full && req_rvalid[g]. This is combinational, and in that cycle master_user_write_buffer=req_rd[g]=1 and input_data=req_rdata[g]. remaining decrements on each write. The cycle of the last write moves to WAIT_DONE.
  - full or !rvalid stalls with no write and no pop.
- WAIT_DONE: master_crtl_done is sampled only here; it is ignored in every other state. When done=1, go to RELEASE.
- RELEASE: pulse req_done[g], set rr pointer=g, return to IDLE.
- Minimum spacing is 2 idle-to-idle cycles. A request asserted while busy waits. req_valid dropped before ack is legal and is not granted.
- Latency for an N-word burst with no stalls: ack at T, go at T+1, writes T+2..T+N+1, done no earlier than T+N+2.
- Width: length = words*BPW, zero-extended to ADDR_W. Requesters keep words*BPW < 2^ADDR_W.

Optional Feature:
DDR_SCHED_TIMEOUT_EN:
- Defined: a counter clears on entry to WAIT_DONE. If done is not seen within TIMEOUT_CYCLES cycles, go to RELEASE and pulse req_err[g] together with req_done[g].
- Undefined: WAIT_DONE waits indefinitely and req_err is tied 0.

Test Plan:
- Req0 addr 0x10000003, words 4, rvalid=1, full=0, done pulled low after go and high 2 cycles after the last write -> ack0 at T, go at T+1, base 0x10000000, length 16, 4 writes, done0 pulse.
- Req0 and req1 valid at the same cycle after reset, 2 words each -> req0 served first, then req1. Next simultaneous pair -> req1 wins? No: rr pointer=1 after the first round, so req0 wins next; verify grants alternate 0,1,0,1.
- full held high 3 cycles mid-burst plus one rvalid gap -> no write or pop while stalled; all 8 words delivered in order, no duplicates.
- words=0 -> ack then done pulse 1 cycle later; go never asserted; base and length still latched.
- reset asserted during STREAM after 2 of 6 words -> next cycle all outputs 0 and state IDLE; no req_done; a new request is then served from index 0.
- With DDR_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, done held 0 -> req_err and req_done pulse together 16 cycles after entering WAIT_DONE; busy drops the cycle after.

Source files
------------

// File: rtl/ddr_write_scheduler_if.sv
// Control and user-buffer port of the DDR burst write master.
// The master modport is the scheduler side; the slave modport is the write master side.
interface ddr_write_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              master_crtl_fixed_location;
    logic [ADDR_W-1:0] master_crtl_write_base;
    logic [ADDR_W-1:0] master_crtl_lenght;
    logic              master_crtl_go;
    logic              master_crtl_done;
    logic              master_user_write_buffer;
    logic [DATA_W-1:0] master_user_buffer_input_data;
    logic              master_user_buffer_full;

    modport master (
        output master_crtl_fixed_location, master_crtl_write_base, master_crtl_lenght,
        output master_crtl_go, master_user_write_buffer, master_user_buffer_input_data,
        input  master_crtl_done, master_user_buffer_full
    );

    modport slave (
        input  master_crtl_fixed_location, master_crtl_write_base, master_crtl_lenght,
        input  master_crtl_go, master_user_write_buffer, master_user_buffer_input_data,
        output master_crtl_done, master_user_buffer_full
    );
endinterface

// File: rtl/ddr_write_scheduler.sv
// Round-robin scheduler sharing one DDR burst write master among NUM_REQ requesters.
// Define DDR_SCHED_TIMEOUT_EN to add a watchdog on master_crtl_done (req_err on expiry).
//
// state       | meaning
// S_IDLE      | waiting for a descriptor; grant, latch and ack happen here
// S_GO        | one-cycle go pulse to the master
// S_STREAM    | moving show-ahead words into the master buffer
// S_WAIT_DONE | waiting for master_crtl_done
// S_RELEASE   | req_done pulse, round-robin pointer moves to the grant
module ddr_write_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]   req_words,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic [NUM_REQ-1:0]         req_rvalid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_rdata,
    output logic [NUM_REQ-1:0]         req_rd,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       busy,
    ddr_write_scheduler_if.master      mst
);
    localparam int BPW = DATA_W / 8;
    localparam int GW  = $clog2(NUM_REQ);

    typedef enum logic [2:0] {S_IDLE, S_GO, S_STREAM, S_WAIT_DONE, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     rr_q, rr_d, gnt_q, gnt_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    logic              any_valid;
    logic [GW-1:0]     pick;
    logic [LEN_W-1:0]  pick_words;
    logic [ADDR_W-1:0] pick_addr;
    logic              wr;
    logic [NUM_REQ-1:0] grant_oh;
    int                idx;

`ifdef DDR_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;
`endif

    // Scan from farthest to nearest after rr_q so the nearest valid index wins.
    always_comb begin
        any_valid = 1'b0;
        pick      = rr_q;
        idx       = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = GW'(idx);
            end
        end
        pick_words = req_words[int'(pick)*LEN_W +: LEN_W];
        pick_addr  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
    end

    assign grant_oh = NUM_REQ'(1) << gnt_q;

    always_comb begin
        wr = 1'b0;
        if (!reset && state_q == S_STREAM)
            wr = !mst.master_user_buffer_full && req_rvalid[gnt_q];
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        base_d  = base_q;
        len_d   = len_q;
        rem_d   = rem_q;
`ifdef DDR_SCHED_TIMEOUT_EN
        tmr_d   = tmr_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    gnt_d   = pick;
                    base_d  = pick_addr & ~ADDR_W'(BPW - 1);
                    len_d   = ADDR_W'(pick_words) * ADDR_W'(BPW);
                    rem_d   = pick_words;
                    state_d = (pick_words == '0) ? S_RELEASE : S_GO;
`ifdef DDR_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_GO: state_d = S_STREAM;
            S_STREAM: begin
                if (wr) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_WAIT_DONE;
`ifdef DDR_SCHED_TIMEOUT_EN
                        tmr_d   = TW'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
            end
            S_WAIT_DONE: begin
                if (mst.master_crtl_done) begin
                    state_d = S_RELEASE;
                end
`ifdef DDR_SCHED_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    state_d = S_RELEASE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
`endif
            end
            S_RELEASE: begin
                rr_d    = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= GW'(NUM_REQ - 1);
            gnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
`ifdef DDR_SCHED_TIMEOUT_EN
            tmr_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
`ifdef DDR_SCHED_TIMEOUT_EN
            tmr_q   <= tmr_d;
            err_q   <= err_d;
`endif
        end
    end

    assign req_ack  = (!reset && state_q == S_IDLE && any_valid) ? (NUM_REQ'(1) << pick) : '0;
    assign req_rd   = wr ? grant_oh : '0;
    assign req_done = (!reset && state_q == S_RELEASE) ? grant_oh : '0;
`ifdef DDR_SCHED_TIMEOUT_EN
    assign req_err  = (!reset && state_q == S_RELEASE && err_q) ? grant_oh : '0;
`else
    assign req_err  = '0;
`endif
    assign busy     = (state_q != S_IDLE);

    assign mst.master_crtl_fixed_location    = 1'b0;
    assign mst.master_crtl_write_base        = base_q;
    assign mst.master_crtl_lenght            = len_q;
    assign mst.master_crtl_go                = (state_q == S_GO);
    assign mst.master_user_write_buffer      = wr;
    assign mst.master_user_buffer_input_data = wr ? req_rdata[int'(gnt_q)*DATA_W +: DATA_W] : '0;
endmodule
